// File: rtl/gpu2d_video_pkg.sv
// ---------------------------------------------------------------------------
// gpu2d_video_pkg : shared types and constants for the scanline VRAM path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gpu2d_video_pkg;

  localparam int H_PIXELS_DEFAULT = 800;
  localparam int V_PIXELS_DEFAULT = 600;

  // Shared with the timing generator, which reads the same banks.
  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/scanline_writer.sv
// ---------------------------------------------------------------------------
// scanline_writer : fills the off-screen VRAM bank with the next scanline
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scanline_writer
  import gpu2d_video_pkg::*;
#(
  parameter int H_PIXELS   = H_PIXELS_DEFAULT,
  parameter int V_PIXELS   = V_PIXELS_DEFAULT,
  parameter int LINE_WIDTH = $clog2(V_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic                   line_parity,
  input  logic [VRAM_DATA_W-1:0] pixel_data,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic [VRAM_ADDR_W-1:0] vram_even_addr,
  output logic [VRAM_DATA_W-1:0] vram_even_data,
  output logic                   vram_even_we,
  output logic [VRAM_ADDR_W-1:0] vram_odd_addr,
  output logic [VRAM_DATA_W-1:0] vram_odd_data,
  output logic                   vram_odd_we,
  output logic [LINE_WIDTH-1:0]  fill_line,
  output logic                   busy,
  output logic                   underrun
);

  localparam logic [VRAM_ADDR_W-1:0] X_LAST    = VRAM_ADDR_W'(H_PIXELS - 1);
  localparam logic [LINE_WIDTH-1:0]  LINE_LAST = LINE_WIDTH'(V_PIXELS - 1);

  fill_state_e              state_q, state_d;
  logic [VRAM_ADDR_W-1:0]   x_q, x_d;
  logic                     target_q, target_d;   // 0 = even bank
  logic [LINE_WIDTH-1:0]    fill_line_q, fill_line_d;
  logic                     underrun_q, underrun_d;
  logic                     even_we_q, even_we_d;
  logic [VRAM_ADDR_W-1:0]   even_addr_q, even_addr_d;
  logic [VRAM_DATA_W-1:0]   even_data_q, even_data_d;
  logic                     odd_we_q, odd_we_d;
  logic [VRAM_ADDR_W-1:0]   odd_addr_q, odd_addr_d;
  logic [VRAM_DATA_W-1:0]   odd_data_q, odd_data_d;
  logic                     accept;

  assign accept = pixel_valid && (state_q == ST_FILL);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    target_d    = target_q;
    fill_line_d = fill_line_q;
    underrun_d  = underrun_q;
    even_we_d   = 1'b0;
    even_addr_d = even_addr_q;
    even_data_d = even_data_q;
    odd_we_d    = 1'b0;
    odd_addr_d  = odd_addr_q;
    odd_data_d  = odd_data_q;

    // The write uses the pre-restart target and x, so a strobe in the same
    // cycle never redirects a pixel already accepted.
    if (accept) begin
      if (target_q) begin
        odd_we_d   = 1'b1;
        odd_addr_d = x_q;
        odd_data_d = pixel_data;
      end else begin
        even_we_d   = 1'b1;
        even_addr_d = x_q;
        even_data_d = pixel_data;
      end
      if (x_q == X_LAST) begin
        x_d     = '0;
        state_d = ST_DONE;
      end else begin
        x_d = x_q + VRAM_ADDR_W'(1);
      end
    end

    if (frame_start) begin
      state_d     = ST_FILL;
      target_d    = 1'b0;
      x_d         = '0;
      fill_line_d = '0;
      underrun_d  = 1'b0;
    end else if (line_start && (state_q != ST_IDLE)) begin
      if (state_q == ST_FILL) begin
        underrun_d = 1'b1;
      end
      x_d = '0;
      if (fill_line_q == LINE_LAST) begin
        state_d = ST_IDLE;
      end else begin
        state_d     = ST_FILL;
        target_d    = ~line_parity;
        fill_line_d = fill_line_q + LINE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      target_q    <= 1'b0;
      fill_line_q <= '0;
      underrun_q  <= 1'b0;
      even_we_q   <= 1'b0;
      even_addr_q <= '0;
      even_data_q <= '0;
      odd_we_q    <= 1'b0;
      odd_addr_q  <= '0;
      odd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      target_q    <= target_d;
      fill_line_q <= fill_line_d;
      underrun_q  <= underrun_d;
      even_we_q   <= even_we_d;
      even_addr_q <= even_addr_d;
      even_data_q <= even_data_d;
      odd_we_q    <= odd_we_d;
      odd_addr_q  <= odd_addr_d;
      odd_data_q  <= odd_data_d;
    end
  end

  assign pixel_ready    = (state_q == ST_FILL);
  assign busy           = (state_q == ST_FILL);
  assign fill_line      = fill_line_q;
  assign underrun       = underrun_q;
  assign vram_even_we   = even_we_q;
  assign vram_even_addr = even_addr_q;
  assign vram_even_data = even_data_q;
  assign vram_odd_we    = odd_we_q;
  assign vram_odd_addr  = odd_addr_q;
  assign vram_odd_data  = odd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_scanline_writer.sv
// ---------------------------------------------------------------------------
// tb_scanline_writer : randomized bench with a behavioural scanline model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scanline_writer;

  localparam int H  = 40;
  localparam int V  = 8;
  localparam int LW = $clog2(V);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          line_start = 1'b0;
  logic          line_parity = 1'b0;
  logic [7:0]    pixel_data = 8'd0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [9:0]    vram_even_addr, vram_odd_addr;
  logic [7:0]    vram_even_data, vram_odd_data;
  logic          vram_even_we, vram_odd_we;
  logic [LW-1:0] fill_line;
  logic          busy, underrun;

  scanline_writer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .line_parity(line_parity), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .vram_even_addr(vram_even_addr), .vram_even_data(vram_even_data), .vram_even_we(vram_even_we),
    .vram_odd_addr(vram_odd_addr), .vram_odd_data(vram_odd_data), .vram_odd_we(vram_odd_we),
    .fill_line(fill_line), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int n_even_w = 0;
  int n_odd_w  = 0;

  // Model: mode 0 idle, 1 filling, 2 line complete
  int m_mode = 0, m_x = 0, m_bank = 0, m_line = 0, m_ur = 0;
  int e_we[2]   = '{0, 0};
  int e_addr[2] = '{0, 0};
  int e_data[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  always @(posedge clk) begin : cmp
    int mode0;
    if (!rst_n) begin
      m_mode = 0; m_x = 0; m_bank = 0; m_line = 0; m_ur = 0;
      e_we = '{0, 0}; e_addr = '{0, 0}; e_data = '{0, 0};
    end else begin
      mode0 = m_mode;
      e_we  = '{0, 0};
      if (pixel_valid && mode0 == 1) begin
        e_we[m_bank]   = 1;
        e_addr[m_bank] = m_x;
        e_data[m_bank] = int'(pixel_data);
        m_x = m_x + 1;
        if (m_x == H) begin
          m_x = 0;
          m_mode = 2;
        end
      end
      if (frame_start) begin
        m_mode = 1; m_bank = 0; m_x = 0; m_line = 0; m_ur = 0;
      end else if (line_start && mode0 != 0) begin
        if (mode0 == 1) m_ur = 1;
        m_x = 0;
        if (m_line == V - 1) m_mode = 0;
        else begin
          m_mode = 1;
          m_bank = line_parity ? 0 : 1;
          m_line = m_line + 1;
        end
      end
    end
    #1;
    check("ready", {31'd0, pixel_ready}, {31'd0, m_mode == 1});
    check("busy", {31'd0, busy}, {31'd0, m_mode == 1});
    check("fill_line", 32'(fill_line), 32'(m_line));
    check("underrun", {31'd0, underrun}, 32'(m_ur));
    check("even_wr", {13'd0, vram_even_we, vram_even_addr, vram_even_data},
          {13'd0, e_we[0] != 0, 10'(e_addr[0]), 8'(e_data[0])});
    check("odd_wr", {13'd0, vram_odd_we, vram_odd_addr, vram_odd_data},
          {13'd0, e_we[1] != 0, 10'(e_addr[1]), 8'(e_data[1])});
    if (vram_even_we) n_even_w++;
    if (vram_odd_we)  n_odd_w++;
  end

  task automatic strobe(input logic fs, input logic ls, input logic par);
    @(negedge clk);
    frame_start = fs; line_start = ls; line_parity = par;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
  endtask

  // Accept n pixels with the given valid duty; ramp data = index when ramp set.
  task automatic feed(input int n, input int pct, input bit ramp);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 20 * n + 100) begin
      @(negedge clk);
      guard++;
      pixel_valid = ($urandom_range(99) < pct);
      pixel_data  = ramp ? acc[7:0] : 8'($urandom);
      if (pixel_valid && pixel_ready) acc++;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    check("feed_accepts", 32'(acc), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, o0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, pixel_ready}, 32'd0);
    check("rst_line", 32'(fill_line), 32'd0);
    check("rst_wr", {vram_even_we, vram_odd_we, vram_even_addr, vram_odd_addr}, 32'd0);
    rst_n = 1'b1;

    // Line 0 into the even bank, ramp data.
    strobe(1'b1, 1'b0, 1'b0);
    e0 = n_even_w; o0 = n_odd_w;
    feed(H, 100, 1'b1);
    @(negedge clk);
    check("s1_busy", {31'd0, busy}, 32'd0);
    check("s1_line", 32'(fill_line), 32'd0);
    check("s1_even_cnt", 32'(n_even_w - e0), 32'(H));
    check("s1_odd_cnt", 32'(n_odd_w - o0), 32'd0);
    check("s1_last", {vram_even_addr, vram_even_data}, {10'(H - 1), 8'(H - 1)});

    // Even displayed -> line 1 into odd bank.
    strobe(1'b0, 1'b1, 1'b0);
    e0 = n_even_w; o0 = n_odd_w;
    feed(H, 100, 1'b0);
    @(negedge clk);
    check("s2_odd_cnt", 32'(n_odd_w - o0), 32'(H));
    check("s2_even_cnt", 32'(n_even_w - e0), 32'd0);
    check("s2_line", 32'(fill_line), 32'd1);
    check("s2_underrun", {31'd0, underrun}, 32'd0);

    // Gappy stream into even bank.
    strobe(1'b0, 1'b1, 1'b1);
    e0 = n_even_w;
    feed(H, 50, 1'b0);
    @(negedge clk);
    check("s3_even_cnt", 32'(n_even_w - e0), 32'(H));

    // Cut a fill short.
    strobe(1'b0, 1'b1, 1'b0);
    feed(15, 70, 1'b0);
    strobe(1'b0, 1'b1, 1'b1);
    check("s4_underrun", {31'd0, underrun}, 32'd1);
    check("s4_line", 32'(fill_line), 32'd4);
    feed(H, 80, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    feed(H, 90, 1'b0);
    check("s4_sticky", {31'd0, underrun}, 32'd1);

    // Whole frame, then the extra line_start parks in IDLE.
    strobe(1'b1, 1'b0, 1'b0);
    check("s5_clear", {31'd0, underrun}, 32'd0);
    for (int l = 0; l < V; l++) begin
      feed(H, 85, 1'b0);
      strobe(1'b0, 1'b1, l[0]);
    end
    check("s5_ready", {31'd0, pixel_ready}, 32'd0);
    check("s5_line", 32'(fill_line), 32'(V - 1));
    e0 = n_even_w; o0 = n_odd_w;
    pixel_valid = 1'b1;
    repeat (20) @(negedge clk);
    pixel_valid = 1'b0;
    @(negedge clk);
    check("s5_no_wr", 32'(n_even_w + n_odd_w - e0 - o0), 32'd0);

    // frame_start + line_start together mid-fill, with a pixel in flight.
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    feed(10, 100, 1'b0);
    @(negedge clk);
    frame_start = 1'b1; line_start = 1'b1; line_parity = 1'b1; pixel_valid = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0; pixel_valid = 1'b0;
    check("s6_underrun", {31'd0, underrun}, 32'd0);
    check("s6_line", 32'(fill_line), 32'd0);
    check("s6_busy", {31'd0, busy}, 32'd1);
    feed(5, 100, 1'b1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    pixel_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("s6_async", {busy, pixel_ready, underrun, vram_even_we, vram_odd_we,
                       vram_even_addr, vram_even_data, 3'(fill_line)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pixel_valid = 1'b0;

    // Random mix of stream stalls and strobes.
    strobe(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pixel_valid = ($urandom_range(99) < 60);
      pixel_data  = 8'($urandom);
      frame_start = ($urandom_range(399) == 0);
      line_start  = ($urandom_range(59) == 0);
      line_parity = 1'($urandom);
    end
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
